// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding Wishbone classic-cycle initiator.
// Accepts one command on a valid/ready port, runs it as one Wishbone read or
// write, and returns one response (data, error flag, timeout flag).
// Optional feature macro: WB_MASTER_TIMEOUT_EN (abort a bus cycle after
// TIMEOUT_CYCLES cycles without ack/err). When undefined, BUS waits forever
// and rsp_timeout is tied low.
module wb_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [DATA_WIDTH-1:0]   cmd_dat,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_dat,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      cyc_q, cyc_d;
    logic                      stb_q, stb_d;
    logic                      we_q, we_d;
    logic [DATA_WIDTH/8-1:0]   sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]     adr_q, adr_d;
    logic [DATA_WIDTH-1:0]     dat_q, dat_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]     rsp_dat_q, rsp_dat_d;
    logic                      rsp_err_q, rsp_err_d;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
`endif

    // Handshake and status decode directly from the state register.
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
`ifdef WB_MASTER_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    // Next-state logic: launch on accept, terminate on ack/err (or timeout),
    // hold the response until the consumer takes it.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
`ifdef WB_MASTER_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wb_ack_i || wb_err_i) begin
                    // Error takes precedence; read data only on a clean ack.
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_dat_d   = (!we_q && wb_ack_i && !wb_err_i) ? wb_dat_i : '0;
                    rsp_err_d   = wb_err_i;
                    rsp_valid_d = 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    state_d     = RESP;
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    cyc_d         = 1'b0;
                    stb_d         = 1'b0;
                    rsp_dat_d     = '0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any cycle or response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master. A behavioural responder is driven
// from the tasks; expected responses come from a rule-level model.
// Timeout scenarios only run when WB_MASTER_TIMEOUT_EN is defined.
module tb_wb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 16;
`ifdef WB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [3:0]    cmd_sel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          busy;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [3:0]    wb_sel_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;

    int vectors    = 0;
    int miscompares = 0;

    wb_cmd_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_dat    (cmd_dat),
        .cmd_sel    (cmd_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_dat    (rsp_dat),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i)
    );

    // Free-running clock.
    always #5 wb_clk_i = ~wb_clk_i;

    // Reference: a command terminated on its (wait_c+1)-th strobe cycle, or
    // aborted after T strobe cycles when the timeout feature is built in.
    function automatic void model(input bit we, input int wait_c, input bit term,
                                  input bit err, input logic [DW-1:0] rdat,
                                  output int stb_cycles, output logic [DW-1:0] e_dat,
                                  output bit e_err, output bit e_to);
        if (term && (!TO_EN || wait_c < T)) begin
            stb_cycles = wait_c + 1;
            e_err      = err;
            e_to       = 1'b0;
            e_dat      = (!we && !err) ? rdat : '0;
        end else begin
            stb_cycles = T;
            e_err      = 1'b0;
            e_to       = 1'b1;
            e_dat      = '0;
        end
    endfunction

    task automatic tick();
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
    endtask

    // One complete transaction from an idle DUT. mode: 0=ack, 1=err, 2=ack+err.
    task automatic run_txn(input string name, input bit we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, input logic [3:0] sel,
                           input int wait_c, input bit term, input int mode,
                           input logic [DW-1:0] rdat, input int stall, input bit trailing);
        int            n;
        int            exp_stb;
        logic [DW-1:0] e_dat;
        bit            e_err;
        bit            e_to;
        bit            bus_ok;
        model(we, wait_c, term, (mode != 0), rdat, exp_stb, e_dat, e_err, e_to);

        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s cmd_ready_idle: got %b want 1", name, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        cmd_we    = ~we;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = 4'($urandom);

        n      = 0;
        bus_ok = 1'b1;
        while (wb_stb_o === 1'b1 && n < 200) begin
            n++;
            if (wb_cyc_o !== 1'b1 || wb_we_o !== we || wb_adr_o !== adr ||
                wb_dat_o !== dat || wb_sel_o !== sel || cmd_ready !== 1'b0 || busy !== 1'b1)
                bus_ok = 1'b0;
            if (term && (n - 1) == wait_c) begin
                wb_ack_i = (mode != 1);
                wb_err_i = (mode != 0);
                wb_dat_i = rdat;
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                wb_dat_i = $urandom;
            end
            tick();
        end
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;

        vectors++;
        if (!bus_ok) begin
            miscompares++;
            $display("FAIL %s bus_outputs: got adr=%h we=%b dat=%h sel=%h want adr=%h we=%b dat=%h sel=%h",
                     name, wb_adr_o, wb_we_o, wb_dat_o, wb_sel_o, adr, we, dat, sel);
        end
        vectors++;
        if (n !== exp_stb) begin
            miscompares++;
            $display("FAIL %s stb_cycles: got %0d want %0d", name, n, exp_stb);
        end
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_dat !== e_dat || rsp_err !== e_err ||
            rsp_timeout !== e_to || wb_cyc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s response: got v=%b dat=%h err=%b to=%b cyc=%b want v=1 dat=%h err=%b to=%b cyc=0",
                     name, rsp_valid, rsp_dat, rsp_err, rsp_timeout, wb_cyc_o, e_dat, e_err, e_to);
        end

        if (trailing) begin
            wb_ack_i = 1'b1;
            wb_dat_i = $urandom;
            tick();
            wb_ack_i = 1'b0;
        end
        for (int i = 0; i < stall; i++) begin
            tick();
        end
        if (trailing || stall > 0) begin
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_dat !== e_dat || rsp_err !== e_err ||
                rsp_timeout !== e_to || wb_cyc_o !== 1'b0 || cmd_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s resp_hold: got v=%b dat=%h err=%b to=%b cyc=%b rdy=%b want v=1 dat=%h err=%b to=%b cyc=0 rdy=0",
                         name, rsp_valid, rsp_dat, rsp_err, rsp_timeout, wb_cyc_o, cmd_ready, e_dat, e_err, e_to);
            end
        end

        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || wb_cyc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s release: got v=%b busy=%b rdy=%b cyc=%b want 0 0 1 0",
                     name, rsp_valid, busy, cmd_ready, wb_cyc_o);
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b0 || wb_stb_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s no_second_rsp: got v=%b stb=%b want 0 0", name, rsp_valid, wb_stb_o);
        end
    endtask

    // Reset state of every registered output and the decoded handshake.
    task automatic test_reset();
        wb_rst_i = 1'b1;
        tick();
        tick();
        wb_rst_i = 1'b0;
        vectors++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, rsp_err, rsp_timeout, busy} !== 7'b0 ||
            wb_sel_o !== 4'h0 || wb_adr_o !== '0 || wb_dat_o !== '0 || rsp_dat !== '0 ||
            cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h v=%b rdat=%h rdy=%b busy=%b want all 0, rdy=1",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, rsp_valid, rsp_dat, cmd_ready, busy);
        end
    endtask

    // Directed write/read/error scenarios from the feature list.
    task automatic test_directed();
        run_txn("write_ack1", 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 1, 1'b1, 0, 32'h0BAD0BAD, 0, 1'b1);
        run_txn("read_wait3", 1'b0, 32'h04, 32'hA5A5A5A5, 4'hF, 3, 1'b1, 0, 32'h12345678, 0, 1'b0);
        run_txn("read_ackerr", 1'b0, 32'h08, 32'h0, 4'hF, 0, 1'b1, 2, 32'hFFFFFFFF, 1, 1'b0);
        run_txn("write_err", 1'b1, 32'h0C, 32'h11223344, 4'h3, 2, 1'b1, 1, 32'hCAFEF00D, 0, 1'b0);
        run_txn("read_zero_wait", 1'b0, 32'h10, 32'h0, 4'h5, 0, 1'b1, 0, 32'h89ABCDEF, 0, 1'b1);
        run_txn("read_ack_last", 1'b0, 32'h14, 32'h0, 4'hF, T - 1, 1'b1, 0, 32'h5555AAAA, 0, 1'b0);
    endtask

    // Timeout abort and the ack-on-expiry-edge race.
    task automatic test_timeout();
`ifdef WB_MASTER_TIMEOUT_EN
        run_txn("timeout_read", 1'b0, 32'h40, 32'h0, 4'hF, 0, 1'b0, 0, 32'h77777777, 0, 1'b1);
        run_txn("timeout_write", 1'b1, 32'h44, 32'h01020304, 4'hC, 0, 1'b0, 0, 32'h0, 2, 1'b0);
        run_txn("ack_on_expiry", 1'b0, 32'h48, 32'h0, 4'hF, T - 1, 1'b1, 0, 32'h600DF00D, 0, 1'b0);
        run_txn("err_on_expiry", 1'b0, 32'h4C, 32'h0, 4'hF, T - 1, 1'b1, 1, 32'h600DF00D, 0, 1'b0);
`endif
    endtask

    // Second command held valid while the first response is stalled.
    task automatic test_back_to_back();
        logic [DW-1:0] held_dat;
        bit            ok;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h100;
        cmd_dat   = 32'hAAAA5555;
        cmd_sel   = 4'hF;
        tick();
        cmd_we    = 1'b0;
        cmd_adr   = 32'h200;
        cmd_dat   = 32'h0;
        cmd_sel   = 4'h6;
        wb_ack_i  = 1'b1;
        wb_dat_i  = 32'h13572468;
        tick();
        wb_ack_i  = 1'b0;
        held_dat  = rsp_dat;
        ok        = (rsp_valid === 1'b1 && rsp_dat === 32'h0 && rsp_err === 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (cmd_ready !== 1'b0 || wb_cyc_o !== 1'b0 || rsp_valid !== 1'b1 ||
                rsp_dat !== held_dat || rsp_err !== 1'b0 || wb_adr_o !== 32'h100)
                ok = 1'b0;
            tick();
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_stall: got rdy=%b cyc=%b v=%b dat=%h adr=%h want rdy=0 cyc=0 v=1 dat=0 adr=100",
                     cmd_ready, wb_cyc_o, rsp_valid, rsp_dat, wb_adr_o);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++;
        if (cmd_ready !== 1'b1 || wb_cyc_o !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap: got rdy=%b cyc=%b v=%b want 1 0 0", cmd_ready, wb_cyc_o, rsp_valid);
        end
        tick();
        cmd_valid = 1'b0;
        vectors++;
        if (wb_stb_o !== 1'b1 || wb_adr_o !== 32'h200 || wb_we_o !== 1'b0 || wb_sel_o !== 4'h6) begin
            miscompares++;
            $display("FAIL b2b_second_issue: got stb=%b adr=%h we=%b sel=%h want 1 200 0 6",
                     wb_stb_o, wb_adr_o, wb_we_o, wb_sel_o);
        end
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hFEEDFACE;
        tick();
        wb_ack_i = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_dat !== 32'hFEEDFACE || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second_rsp: got v=%b dat=%h err=%b want 1 feedface 0", rsp_valid, rsp_dat, rsp_err);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Reset pulse in the middle of a bus cycle, then a normal command.
    task automatic test_reset_mid_bus();
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h300;
        cmd_sel   = 4'hF;
        tick();
        cmd_valid = 1'b0;
        tick();
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        vectors++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_bus: got cyc=%b stb=%b v=%b busy=%b want 0 0 0 0",
                     wb_cyc_o, wb_stb_o, rsp_valid, busy);
        end
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hBAADBAAD;
        tick();
        wb_ack_i = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_stray_ack: got v=%b cyc=%b want 0 0", rsp_valid, wb_cyc_o);
        end
        run_txn("after_reset", 1'b0, 32'h304, 32'h0, 4'hF, 1, 1'b1, 0, 32'h0F0F0F0F, 0, 1'b0);
    endtask

    // Randomized commands and responder behaviour against the model.
    task automatic test_random();
        bit term;
        for (int i = 0; i < 24; i++) begin
            term = TO_EN ? ($urandom_range(0, 5) != 0) : 1'b1;
            run_txn("random", 1'($urandom), $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 6), term, $urandom_range(0, 2), $urandom,
                    $urandom_range(0, 2), 1'($urandom));
        end
    endtask

    // Test sequence.
    initial begin
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wb_dat_i  = '0;
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        @(negedge wb_clk_i);
        test_reset();
        test_directed();
        test_timeout();
        test_back_to_back();
        test_reset_mid_bus();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
